// File: rtl/ppu_vram_port_pkg.sv
// ppu_vram_port_pkg: register indices, state encoding and address constants shared by the PPUDATA/PPUADDR access engine.
package ppu_vram_port_pkg;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_ADDR = 3'd6;
  localparam logic [2:0] REG_DATA = 3'd7;
  localparam int INC1 = 1;
  localparam int INC32 = 32;
  localparam logic [13:0] PAL_BASE = 14'h3F00;
  localparam logic [13:0] NT_OFFSET = 14'h1000;
  typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, PAL_RD, PAL_CAP} state_e;
  function automatic logic is_pal(input logic [13:0] a);
    return a[13:8] == PAL_BASE[13:8];
  endfunction
endpackage

// File: rtl/ppu_vram_port_if.sv
// ppu_vram_port_if: CPU register strobes plus the VRAM request/response bus of the access engine.
interface ppu_vram_port_if;
  logic [2:0] reg_sel;
  logic cpu_wr;
  logic cpu_rd;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic ctrl_inc32;
  logic busy;
  logic [15:0] vram_addr;
  logic vram_wr_en;
  logic [7:0] vram_wdata;
  logic vram_rd_en;
  logic [7:0] vram_rdata;
  modport master (
    output reg_sel, cpu_wr, cpu_rd, cpu_wdata, ctrl_inc32, vram_rdata,
    input cpu_rdata, busy, vram_addr, vram_wr_en, vram_wdata, vram_rd_en
  );
  modport slave (
    input reg_sel, cpu_wr, cpu_rd, cpu_wdata, ctrl_inc32, vram_rdata,
    output cpu_rdata, busy, vram_addr, vram_wr_en, vram_wdata, vram_rd_en
  );
endinterface

// File: rtl/ppu_vram_port_vaddr_reg.sv
// ppu_vaddr_reg: VRAM address v, high-byte latch t_hi and write toggle w with the post-access incrementer.
module ppu_vaddr_reg
  import ppu_vram_port_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addr_wr,
  input  logic              clr_w,
  input  logic              inc_en,
  input  logic              inc32,
  input  logic [7:0]        wdata,
  output logic [ADDR_W-1:0] v
);
  logic [ADDR_W-1:0] v_q, v_d;
  logic [ADDR_W-9:0] t_q, t_d;
  logic w_q, w_d;
  always_comb begin
    w_d = addr_wr ? !w_q : (clr_w ? 1'b0 : w_q);
    t_d = (addr_wr && !w_q) ? wdata[ADDR_W-9:0] : t_q;
    v_d = (addr_wr && w_q) ? {t_q, wdata} : (inc_en ? v_q + ADDR_W'(inc32 ? INC32 : INC1) : v_q);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= RST_ADDR;
      t_q <= '0;
      w_q <= 1'b0;
    end else begin
      v_q <= v_d;
      t_q <= t_d;
      w_q <= w_d;
    end
  end
  assign v = v_q;
endmodule

// File: rtl/ppu_vram_port.sv
// ppu_vram_port: PPUADDR/PPUDATA access engine sequencing VRAM reads and writes for the CPU.
// Define PPU_PAL_RD_BYPASS_EN to return palette reads directly while refilling the buffer from the nametable beneath.
module ppu_vram_port
  import ppu_vram_port_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
  input logic         clk,
  input logic         rst_n,
  ppu_vram_port_if.slave bus
);
  state_e state_q, state_d;
  logic [7:0] rd_buf_q, rd_buf_d, rdata_q, rdata_d, wdata_q, wdata_d;
  logic inc32_q, inc32_d;
  logic [ADDR_W-1:0] v, rd_addr;
  logic idle, wr_go, rd_go, addr_wr, clr_w, inc_en;
  assign idle = state_q == IDLE;
  assign wr_go = idle && bus.cpu_wr;
  assign rd_go = idle && bus.cpu_rd && !bus.cpu_wr;
  assign addr_wr = wr_go && bus.reg_sel == REG_ADDR;
  assign clr_w = rd_go && bus.reg_sel == REG_STATUS;
  assign inc_en = state_q == WR || state_q == RD_CAP;
  ppu_vaddr_reg #(.ADDR_W(ADDR_W), .RST_ADDR(RST_ADDR)) u_vaddr (
    .clk(clk), .rst_n(rst_n), .addr_wr(addr_wr), .clr_w(clr_w),
    .inc_en(inc_en), .inc32(inc32_q), .wdata(bus.cpu_wdata), .v(v)
  );
  always_comb begin
    state_d = IDLE;
    rd_buf_d = rd_buf_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    inc32_d = inc32_q;
    case (state_q)
      IDLE: begin
        if (wr_go && bus.reg_sel == REG_DATA) begin
          state_d = WR;
          wdata_d = bus.cpu_wdata;
          inc32_d = bus.ctrl_inc32;
        end else if (rd_go && bus.reg_sel == REG_DATA) begin
          rdata_d = rd_buf_q;
          inc32_d = bus.ctrl_inc32;
`ifdef PPU_PAL_RD_BYPASS_EN
          state_d = is_pal(v) ? PAL_RD : RD;
`else
          state_d = RD;
`endif
        end
      end
      RD: state_d = RD_CAP;
      RD_CAP: rd_buf_d = bus.vram_rdata;
`ifdef PPU_PAL_RD_BYPASS_EN
      PAL_RD: state_d = PAL_CAP;
      PAL_CAP: begin
        rdata_d = bus.vram_rdata;
        state_d = RD;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_buf_q <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      inc32_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_buf_q <= rd_buf_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      inc32_q <= inc32_d;
    end
  end
`ifdef PPU_PAL_RD_BYPASS_EN
  // the buffer refill behind a palette read comes from the nametable mirror underneath
  assign rd_addr = (state_q == RD && is_pal(v)) ? v - ADDR_W'(NT_OFFSET) : v;
`else
  assign rd_addr = v;
`endif
  assign bus.busy = !idle;
  assign bus.vram_wr_en = state_q == WR;
  assign bus.vram_rd_en = state_q == RD || state_q == PAL_RD;
  assign bus.vram_wdata = wdata_q;
  assign bus.vram_addr = 16'(rd_addr);
  assign bus.cpu_rdata = rdata_q;
endmodule

// File: tb/tb_ppu_vram_port.sv
// tb_ppu_vram_port: directed checks of the PPUADDR/PPUDATA engine against a small VRAM model.
module tb_ppu_vram_port;
  logic clk, rst_n;
  ppu_vram_port_if bus();
  ppu_vram_port dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks, errors, wcnt, n;
  logic [7:0] mem [0:16383];
  logic [15:0] wa [0:15];
  logic [7:0] wd [0:15];
  logic pk_en;
  logic [13:0] pk_a;
  logic [7:0] pk_d;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial wcnt = 0;
  always @(posedge clk) begin
    if (pk_en) mem[pk_a] <= pk_d;
    if (bus.vram_wr_en) begin
      mem[bus.vram_addr[13:0]] <= bus.vram_wdata;
      wa[wcnt[3:0]] <= bus.vram_addr;
      wd[wcnt[3:0]] <= bus.vram_wdata;
      wcnt <= wcnt + 1;
    end
    if (bus.vram_rd_en) bus.vram_rdata <= mem[bus.vram_addr[13:0]];
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic strobe(input logic [2:0] rs, input logic wr, input logic rd, input logic [7:0] d);
    bus.reg_sel = rs;
    bus.cpu_wr = wr;
    bus.cpu_rd = rd;
    bus.cpu_wdata = d;
    @(negedge clk);
    bus.cpu_wr = 1'b0;
    bus.cpu_rd = 1'b0;
  endtask
  task automatic set_v(input logic [13:0] a);
    strobe(3'd6, 1'b1, 1'b0, {2'b00, a[13:8]});
    strobe(3'd6, 1'b1, 1'b0, a[7:0]);
  endtask
  task automatic poke(input logic [13:0] a, input logic [7:0] d);
    pk_a = a;
    pk_d = d;
    pk_en = 1'b1;
    @(negedge clk);
    pk_en = 1'b0;
  endtask
  task automatic run_idle(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("idle_timeout", 16'(bus.busy), 16'h0);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    pk_en = 1'b0;
    pk_a = '0;
    pk_d = '0;
    rst_n = 1'b0;
    bus.reg_sel = '0;
    bus.cpu_wr = 1'b0;
    bus.cpu_rd = 1'b0;
    bus.cpu_wdata = '0;
    bus.ctrl_inc32 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_wr_en", 16'(bus.vram_wr_en), 16'h0);
    chk("rst_rd_en", 16'(bus.vram_rd_en), 16'h0);
    chk("rst_rdata", 16'(bus.cpu_rdata), 16'h0);
    chk("rst_wdata", 16'(bus.vram_wdata), 16'h0);
    chk("rst_addr", bus.vram_addr, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    strobe(3'd6, 1'b1, 1'b0, 8'h21);
    chk("2006_no_busy", 16'(bus.busy), 16'h0);
    strobe(3'd6, 1'b1, 1'b0, 8'h08);
    chk("v_2108", bus.vram_addr, 16'h2108);
    strobe(3'd7, 1'b1, 1'b0, 8'hAB);
    chk("wr_en", 16'(bus.vram_wr_en), 16'h1);
    chk("wr_addr", bus.vram_addr, 16'h2108);
    chk("wr_data", 16'(bus.vram_wdata), 16'h00AB);
    run_idle(n);
    chk("wr_busy_cycles", 16'(n), 16'd1);
    chk("v_2109", bus.vram_addr, 16'h2109);
    chk("wcnt_1", 16'(wcnt), 16'd1);
    chk("mem_2108", 16'(wd[0]), 16'h00AB);
    set_v(14'h2000);
    bus.ctrl_inc32 = 1'b1;
    strobe(3'd7, 1'b1, 1'b0, 8'h11);
    bus.ctrl_inc32 = 1'b0;
    run_idle(n);
    bus.ctrl_inc32 = 1'b1;
    strobe(3'd7, 1'b1, 1'b0, 8'h22);
    bus.ctrl_inc32 = 1'b0;
    run_idle(n);
    chk("inc32_wa0", wa[1], 16'h2000);
    chk("inc32_wa1", wa[2], 16'h2020);
    chk("inc32_v", bus.vram_addr, 16'h2040);
    poke(14'h2400, 8'h55);
    poke(14'h2401, 8'h5A);
    set_v(14'h2400);
    strobe(3'd7, 1'b0, 1'b1, 8'h00);
    chk("rd1_rdata", 16'(bus.cpu_rdata), 16'h0000);
    chk("rd1_rd_en", 16'(bus.vram_rd_en), 16'h1);
    chk("rd1_addr", bus.vram_addr, 16'h2400);
    run_idle(n);
    chk("rd_busy_cycles", 16'(n), 16'd2);
    strobe(3'd7, 1'b0, 1'b1, 8'h00);
    chk("rd2_rdata", 16'(bus.cpu_rdata), 16'h0055);
    run_idle(n);
    chk("rd2_v", bus.vram_addr, 16'h2402);
    strobe(3'd6, 1'b1, 1'b0, 8'h3F);
    strobe(3'd2, 1'b0, 1'b1, 8'h00);
    strobe(3'd6, 1'b1, 1'b0, 8'h12);
    chk("w_clr_v_kept", bus.vram_addr, 16'h2402);
    strobe(3'd6, 1'b1, 1'b0, 8'h34);
    chk("w_clr_v_1234", bus.vram_addr, 16'h1234);
    set_v(14'h3FFF);
    strobe(3'd7, 1'b1, 1'b0, 8'h77);
    run_idle(n);
    chk("wrap_wr_addr", wa[3], 16'h3FFF);
    chk("wrap_v", bus.vram_addr, 16'h0000);
    strobe(3'd7, 1'b1, 1'b1, 8'h99);
    chk("both_wr_en", 16'(bus.vram_wr_en), 16'h1);
    chk("both_rd_en", 16'(bus.vram_rd_en), 16'h0);
    run_idle(n);
    chk("both_rdata_kept", 16'(bus.cpu_rdata), 16'h0055);
    chk("both_v", bus.vram_addr, 16'h0001);
    chk("both_wd", 16'(wd[4]), 16'h0099);
    strobe(3'd7, 1'b1, 1'b0, 8'h44);
    strobe(3'd7, 1'b1, 1'b0, 8'hEE);
    run_idle(n);
    chk("busy_ignore_wcnt", 16'(wcnt), 16'd6);
    chk("busy_ignore_v", bus.vram_addr, 16'h0002);
    poke(14'h3F01, 8'h0F);
    poke(14'h2F01, 8'h33);
    set_v(14'h3F01);
    strobe(3'd7, 1'b0, 1'b1, 8'h00);
    chk("pal_rd_en", 16'(bus.vram_rd_en), 16'h1);
    chk("pal_addr", bus.vram_addr, 16'h3F01);
`ifdef PPU_PAL_RD_BYPASS_EN
    @(negedge clk);
    @(negedge clk);
    chk("pal_nt_rd_en", 16'(bus.vram_rd_en), 16'h1);
    chk("pal_nt_addr", bus.vram_addr, 16'h2F01);
    run_idle(n);
    chk("pal_tail_cycles", 16'(n), 16'd2);
    chk("pal_rdata", 16'(bus.cpu_rdata), 16'h000F);
`else
    run_idle(n);
    chk("pal_busy_cycles", 16'(n), 16'd2);
    chk("pal_rdata", 16'(bus.cpu_rdata), 16'h005A);
`endif
    chk("pal_v", bus.vram_addr, 16'h3F02);
    set_v(14'h2000);
    strobe(3'd7, 1'b0, 1'b1, 8'h00);
`ifdef PPU_PAL_RD_BYPASS_EN
    chk("pal_rd_buf", 16'(bus.cpu_rdata), 16'h0033);
`else
    chk("pal_rd_buf", 16'(bus.cpu_rdata), 16'h000F);
`endif
    run_idle(n);
    strobe(3'd7, 1'b0, 1'b1, 8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 16'(bus.busy), 16'h0);
    chk("mid_rst_rd_en", 16'(bus.vram_rd_en), 16'h0);
    chk("mid_rst_rdata", 16'(bus.cpu_rdata), 16'h0000);
    chk("mid_rst_wdata", 16'(bus.vram_wdata), 16'h0000);
    chk("mid_rst_addr", bus.vram_addr, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    strobe(3'd7, 1'b0, 1'b1, 8'h00);
    chk("mid_rst_rd_buf", 16'(bus.cpu_rdata), 16'h0000);
    run_idle(n);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
